// File: rtl/mtimer_pkg.sv
// Shared definitions for the machine timer: bus offsets and the XLEN define used by the CSR files.
`ifndef XLEN
`define XLEN 32
`endif

package mtimer_pkg;

  localparam logic [3:0] MTIME_LO    = 4'h0;
  localparam logic [3:0] MTIME_HI    = 4'h4;
  localparam logic [3:0] MTIMECMP_LO = 4'h8;
  localparam logic [3:0] MTIMECMP_HI = 4'hC;

  function automatic logic word_aligned(input logic [3:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/mtimer_prescale.sv
// Prescale counter for mtime: counts 0..PRESCALE-1 and flags a tick on the last count.
module mtimer_prescale #(
  parameter int PRESCALE = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clear,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] cnt_reg;

  assign tick = (cnt_reg == LAST);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_reg <= '0;
    end else if (clear || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

endmodule

// File: rtl/mtimer.sv
// Memory-mapped RISC-V machine timer (mtime/mtimecmp) with single-cycle bus acknowledge.
// Define MTIMER_HI_LATCH_EN to latch mtime[63:32] on a low-half read for tear-free 64-bit reads.
`ifndef XLEN
`define XLEN 32
`endif

module mtimer
  import mtimer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [3:0]        i_addr,
  input  logic [`XLEN-1:0]  i_wdata,
  output logic [`XLEN-1:0]  o_rdata,
  output logic              o_ack,
  output logic              o_err,
  output logic              o_Int_tip
);

  logic [63:0]       mtime_reg;
  logic [63:0]       mtime_next;
  logic [63:0]       mtimecmp_reg;
  logic [63:0]       mtimecmp_next;
  logic [`XLEN-1:0]  rdata_next;
  logic [31:0]       mtime_hi_rd;
  logic              aligned;
  logic              wr;
  logic              rd;
  logic              wr_mtime_lo;
  logic              wr_mtime_hi;
  logic              tick;

  assign aligned     = word_aligned(i_addr);
  assign wr          = i_req & i_we & aligned;
  assign rd          = i_req & ~i_we & aligned;
  assign wr_mtime_lo = wr && (i_addr == MTIME_LO);
  assign wr_mtime_hi = wr && (i_addr == MTIME_HI);

  mtimer_prescale #(
    .PRESCALE (PRESCALE)
  ) u_prescale (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .clear (wr_mtime_lo | wr_mtime_hi),
    .tick  (tick)
  );

`ifdef MTIMER_HI_LATCH_EN
  logic [31:0] hi_shadow_reg;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      hi_shadow_reg <= '0;
    end else if (rd && (i_addr == MTIME_LO)) begin
      hi_shadow_reg <= mtime_reg[63:32];
    end
  end

  assign mtime_hi_rd = hi_shadow_reg;
`else
  assign mtime_hi_rd = mtime_reg[63:32];
`endif

  // A software load of either half takes priority over the tick in that cycle.
  always_comb begin
    mtime_next = mtime_reg;
    if (wr_mtime_lo) begin
      mtime_next[31:0] = i_wdata;
    end else if (wr_mtime_hi) begin
      mtime_next[63:32] = i_wdata;
    end else if (tick) begin
      mtime_next = mtime_reg + 64'd1;
    end
  end

  always_comb begin
    mtimecmp_next = mtimecmp_reg;
    if (wr && (i_addr == MTIMECMP_LO)) begin
      mtimecmp_next[31:0] = i_wdata;
    end else if (wr && (i_addr == MTIMECMP_HI)) begin
      mtimecmp_next[63:32] = i_wdata;
    end
  end

  always_comb begin
    rdata_next = '0;
    if (rd) begin
      case (i_addr)
        MTIME_LO:    rdata_next = mtime_reg[31:0];
        MTIME_HI:    rdata_next = mtime_hi_rd;
        MTIMECMP_LO: rdata_next = mtimecmp_reg[31:0];
        MTIMECMP_HI: rdata_next = mtimecmp_reg[63:32];
        default:     rdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      mtime_reg    <= '0;
      mtimecmp_reg <= '1;
      o_ack        <= 1'b0;
      o_err        <= 1'b0;
      o_rdata      <= '0;
      o_Int_tip    <= 1'b0;
    end else begin
      mtime_reg    <= mtime_next;
      mtimecmp_reg <= mtimecmp_next;
      o_ack        <= i_req;
      o_err        <= i_req & ~aligned;
      o_rdata      <= rdata_next;
      o_Int_tip    <= (mtime_reg >= mtimecmp_reg);
    end
  end

endmodule

// File: tb/tb_mtimer.sv
// Directed bench for mtimer: one instance at PRESCALE=1 and one at PRESCALE=4 sharing clock, reset and bus data.
module tb_mtimer;

  logic        clk;
  logic        rst_n;
  logic        req1;
  logic        req4;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata1;
  logic [31:0] rdata4;
  logic        ack1;
  logic        ack4;
  logic        err1;
  logic        err4;
  logic        tip1;
  logic        tip4;

  int total = 0;
  int bad   = 0;

  mtimer #(.PRESCALE(1)) dut1 (
    .i_clk(clk), .i_rst(rst_n), .i_req(req1), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .o_rdata(rdata1), .o_ack(ack1), .o_err(err1), .o_Int_tip(tip1)
  );

  mtimer #(.PRESCALE(4)) dut4 (
    .i_clk(clk), .i_rst(rst_n), .i_req(req4), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .o_rdata(rdata4), .o_ack(ack4), .o_err(err4), .o_Int_tip(tip4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One bus access; consecutive calls are back-to-back on the bus.
  task automatic access(input bit sel4, input bit w, input logic [3:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic ack, output logic err);
    we    = w;
    addr  = a;
    wdata = d;
    if (sel4) req4 = 1'b1;
    else      req1 = 1'b1;
    cyc();
    req1 = 1'b0;
    req4 = 1'b0;
    rd   = sel4 ? rdata4 : rdata1;
    ack  = sel4 ? ack4 : ack1;
    err  = sel4 ? err4 : err1;
    $display("txn dut%0d %s addr=%h wdata=%h -> ack=%b err=%b rdata=%h",
             sel4 ? 4 : 1, w ? "WR" : "RD", a, d, ack, err, rd);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req1 = 1'b0; req4 = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) cyc();
    total++;
    if ({ack1, err1, tip1, rdata1} !== 35'd0) begin
      bad++; $display("FAIL reset_dut1: got ack=%b err=%b tip=%b rdata=%h want all 0", ack1, err1, tip1, rdata1);
    end
    total++;
    if ({ack4, err4, tip4, rdata4} !== 35'd0) begin
      bad++; $display("FAIL reset_dut4: got ack=%b err=%b tip=%b rdata=%h want all 0", ack4, err4, tip4, rdata4);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_count();
    logic [31:0] rd; logic ack, err;
    for (int i = 0; i < 10; i++) begin
      cyc();
      total++;
      if (tip1 !== 1'b0) begin bad++; $display("FAIL count_tip cycle %0d: got %b want 0", i, tip1); end
    end
    access(0, 0, 4'h0, 32'h0, rd, ack, err);
    total++;
    if (ack !== 1'b1 || err !== 1'b0 || rd !== 32'd10) begin
      bad++; $display("FAIL count_read: got ack=%b err=%b rdata=%0d want ack=1 err=0 rdata=10", ack, err, rd);
    end
  endtask

  task automatic test_carry();
    logic [31:0] rd; logic ack, err;
    logic [31:0] exp_lo [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    access(1, 1, 4'h0, 32'hFFFF_FFFF, rd, ack, err);
    total++;
    if (ack !== 1'b1 || err !== 1'b0 || rd !== 32'h0) begin
      bad++; $display("FAIL carry_wr_lo: got ack=%b err=%b rdata=%h want 1 0 0", ack, err, rd);
    end
    access(1, 1, 4'h4, 32'h0, rd, ack, err);
    total++;
    if (ack !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL carry_wr_hi: got ack=%b rdata=%h want 1 0", ack, rd);
    end
    for (int i = 0; i < 5; i++) begin
      access(1, 0, 4'h0, 32'h0, rd, ack, err);
      total++;
      if (ack !== 1'b1 || rd !== exp_lo[i]) begin
        bad++; $display("FAIL carry_lo_%0d: got ack=%b rdata=%h want 1 %h", i, ack, rd, exp_lo[i]);
      end
    end
    access(1, 0, 4'h4, 32'h0, rd, ack, err);
    total++;
    if (ack !== 1'b1 || rd !== 32'h1) begin
      bad++; $display("FAIL carry_hi: got ack=%b rdata=%h want 1 00000001", ack, rd);
    end
  endtask

  task automatic test_compare();
    logic [31:0] rd; logic ack, err;
    access(0, 1, 4'h4, 32'h0, rd, ack, err);
    access(0, 1, 4'h0, 32'h0, rd, ack, err);
    access(0, 1, 4'hC, 32'h0, rd, ack, err);
    access(0, 1, 4'h8, 32'd20, rd, ack, err);
    // mtime is k-1 after the k-th edge counted from the mtime-hi write; tip follows one edge after 20.
    for (int k = 4; k <= 24; k++) begin
      cyc();
      total++;
      if (tip1 !== (k >= 22)) begin
        bad++; $display("FAIL cmp_tip k=%0d: got %b want %b", k, tip1, (k >= 22));
      end
    end
    access(0, 1, 4'h8, 32'hFFFF_FFFF, rd, ack, err);
    total++;
    if (tip1 !== 1'b1) begin bad++; $display("FAIL cmp_tip_hold: got %b want 1", tip1); end
    cyc();
    total++;
    if (tip1 !== 1'b0) begin bad++; $display("FAIL cmp_tip_fall: got %b want 0", tip1); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic ack, err;
    access(0, 0, 4'h6, 32'h0, rd, ack, err);
    total++;
    if (ack !== 1'b1 || err !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL mis_read: got ack=%b err=%b rdata=%h want 1 1 0", ack, err, rd);
    end
    cyc();
    total++;
    if (ack1 !== 1'b0 || err1 !== 1'b0) begin
      bad++; $display("FAIL mis_ack_once: got ack=%b err=%b want 0 0", ack1, err1);
    end
    access(0, 1, 4'hA, 32'h1234_5678, rd, ack, err);
    total++;
    if (ack !== 1'b1 || err !== 1'b1) begin
      bad++; $display("FAIL mis_write: got ack=%b err=%b want 1 1", ack, err);
    end
    access(0, 0, 4'h8, 32'h0, rd, ack, err);
    total++;
    if (err !== 1'b0 || rd !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL mis_cmp_lo: got err=%b rdata=%h want 0 ffffffff", err, rd);
    end
    access(0, 0, 4'hC, 32'h0, rd, ack, err);
    total++;
    if (err !== 1'b0 || rd !== 32'h0) begin
      bad++; $display("FAIL mis_cmp_hi: got err=%b rdata=%h want 0 0", err, rd);
    end
  endtask

  task automatic test_hi_latch();
    logic [31:0] rd; logic ack, err;
    logic [31:0] exp_hi;
`ifdef MTIMER_HI_LATCH_EN
    exp_hi = 32'h0;
`else
    exp_hi = 32'h1;
`endif
    access(1, 1, 4'h4, 32'h0, rd, ack, err);
    access(1, 1, 4'h0, 32'hFFFF_FFFF, rd, ack, err);
    access(1, 0, 4'h0, 32'h0, rd, ack, err);
    total++;
    if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL latch_lo: got %h want ffffffff", rd); end
    repeat (3) cyc();
    access(1, 0, 4'h4, 32'h0, rd, ack, err);
    total++;
    if (rd !== exp_hi) begin bad++; $display("FAIL latch_hi: got %h want %h", rd, exp_hi); end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] rd; logic ack, err;
    we = 1'b0; addr = 4'h0; req1 = 1'b1;
    cyc();
    rst_n = 1'b0;
    req1  = 1'b0;
    #1;
    total++;
    if ({ack1, err1, tip1, rdata1} !== 35'd0) begin
      bad++; $display("FAIL rst_async: got ack=%b err=%b tip=%b rdata=%h want all 0", ack1, err1, tip1, rdata1);
    end
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    total++;
    if (ack1 !== 1'b0 || ack4 !== 1'b0) begin
      bad++; $display("FAIL rst_no_ack: got ack1=%b ack4=%b want 0 0", ack1, ack4);
    end
    access(1, 0, 4'h0, 32'h0, rd, ack, err);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL rst_dut4_mtime: got %h want 0", rd); end
    access(0, 0, 4'h0, 32'h0, rd, ack, err);
    total++;
    if (rd !== 32'd2) begin bad++; $display("FAIL rst_mtime_lo: got %h want 2", rd); end
    access(0, 0, 4'h4, 32'h0, rd, ack, err);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL rst_mtime_hi: got %h want 0", rd); end
    access(0, 0, 4'h8, 32'h0, rd, ack, err);
    total++;
    if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_cmp_lo: got %h want ffffffff", rd); end
    access(0, 0, 4'hC, 32'h0, rd, ack, err);
    total++;
    if (rd !== 32'hFFFF_FFFF || tip1 !== 1'b0) begin
      bad++; $display("FAIL rst_cmp_hi: got rdata=%h tip=%b want ffffffff 0", rd, tip1);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_carry();
    test_compare();
    test_misaligned();
    test_hi_latch();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mtimer.md
MTIMER -- requirements
Module: mtimer

Interface
REQ-001 SHALL have parameter PRESCALE, default 1, meaning clock cycles per mtime increment (legal range 1..65535).
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state SHALL be on its rising edge.
REQ-003 SHALL have port i_rst, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port i_req, input, 1, bus access request, valid for one cycle per access.
REQ-005 SHALL have port i_we, input, 1, 1 = write and 0 = read, qualified by i_req.
REQ-006 SHALL have port i_addr, input, 4, byte offset: 0x0 mtime[31:0], 0x4 mtime[63:32], 0x8 mtimecmp[31:0], 0xC mtimecmp[63:32].
REQ-007 SHALL have port i_wdata, input, `XLEN (32), write data.
REQ-008 SHALL have port o_rdata, output, `XLEN, read data, valid only while o_ack=1.
REQ-009 SHALL have port o_ack, output, 1, access complete.
REQ-010 SHALL have port o_err, output, 1, access rejected, valid only while o_ack=1.
REQ-011 SHALL have port o_Int_tip, output, 1, machine timer interrupt pending; feeds the CSR i_Int_tip input.

Function
REQ-012 On every i_req, o_ack SHALL be 1 in exactly the next cycle for one cycle; requests on back-to-back cycles SHALL each be acknowledged, with no stall.
REQ-013 o_rdata SHALL hold the addressed register value as sampled in the request cycle, before any same-cycle update; otherwise it SHALL be 0, including for writes.
REQ-014 If i_addr[1:0]!=0, the response SHALL be o_err=1 with o_rdata=0, and the write SHALL be ignored; o_err SHALL be 0 in all other cases.
REQ-015 A prescale counter SHALL count 0..PRESCALE-1 and wrap to 0; a tick SHALL occur on the cycle it holds PRESCALE-1.
REQ-016 On each tick, mtime SHALL increment by 1 as a 64-bit value; carry SHALL propagate into mtime[63:32]; all-ones SHALL wrap to 0.
REQ-017 A write to either half of mtime SHALL load that half and leave the other half unchanged; in that cycle the increment SHALL be suppressed and the prescale counter SHALL be cleared to 0.
REQ-018 A write to either half of mtimecmp SHALL load that half only.
REQ-019 o_Int_tip SHALL be registered as (mtime >= mtimecmp), an unsigned 64-bit compare of the current-cycle register values; latency is one cycle after the register changes.
REQ-020 o_Int_tip SHALL stay asserted while the condition holds and SHALL clear only by a write that makes the condition false; there SHALL be no sticky state.
REQ-021 Split 32-bit mtimecmp writes MAY glitch o_Int_tip transiently; software SHALL write mtimecmp[63:32]=all-ones first. The block SHALL NOT mask this.

Reset
REQ-022 On i_rst=0, asynchronously: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescale counter=0, o_ack=0, o_err=0, o_rdata=0, o_Int_tip=0, hi-shadow=0.
REQ-023 A request in flight when reset asserts SHALL be dropped, with no ack after reset deasserts.

Configuration
REQ-024 Macro MTIMER_HI_LATCH_EN: when defined, a read of offset 0x0 SHALL also capture mtime[63:32] into a shadow register, and a read of 0x4 SHALL return that shadow, giving a tear-free 64-bit read.
REQ-025 Without MTIMER_HI_LATCH_EN, a read of 0x4 SHALL return live mtime[63:32] and no shadow register SHALL exist.

Structure
REQ-026 The offset constants (MTIME_LO, MTIME_HI, MTIMECMP_LO, MTIMECMP_HI) SHALL live in shared package mtimer_pkg, alongside the existing CSR defines.
REQ-027 The prescale counter and tick generation SHALL be sub-module mtimer_prescale (input clear; output tick).

Verification
REQ-028 PRESCALE=1, reset released, idle 10 cycles -> read 0x0 returns 10±1 (exact per bench alignment); o_Int_tip=0 throughout.
REQ-029 PRESCALE=4: write mtime lo=0xFFFF_FFFF and hi=0, then wait 4 cycles -> mtime = 64'h1_0000_0000 (carry), and the increment cycle count is confirmed exactly.
REQ-030 Write mtimecmp hi=0, lo=20 with mtime=0 -> o_Int_tip rises exactly one cycle after mtime reaches 20. Then write mtimecmp lo=0xFFFF_FFFF -> o_Int_tip falls one cycle later.
REQ-031 Read at i_addr=0x6 -> o_ack=1 and o_err=1 the next cycle, o_rdata=0, no register changes. Write at 0xA -> mtimecmp unchanged.
REQ-032 With MTIMER_HI_LATCH_EN: set mtime=0x0000_0000_FFFF_FFFF, read lo, tick, then read hi -> returns 0. Without the macro -> returns 1.
REQ-033 Assert i_rst mid-run, one cycle after i_req -> no o_ack is ever seen, and all outputs and registers equal their REQ-022 values.
